// File: rtl/spi_pkg.sv
// Shared opcodes, accelerometer axis addresses and FSM encoding for spi_burst_master.
package spi_pkg;

  localparam logic [7:0] OP_WRITE   = 8'h0A;
  localparam logic [7:0] OP_REG_RD  = 8'h0B;
  localparam logic [7:0] OP_FIFO_RD = 8'h0D;

  localparam logic [7:0] ACC_X_ADDR = 8'h08;
  localparam logic [7:0] ACC_Y_ADDR = 8'h09;
  localparam logic [7:0] ACC_Z_ADDR = 8'h0A;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_HEADER,
    ST_DATA,
    ST_HOLD,
    ST_GAP
  } state_t;

  function automatic logic op_valid(input logic [7:0] op);
    return (op == OP_WRITE) || (op == OP_REG_RD) || (op == OP_FIFO_RD);
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK divider: counts CLK_DIV cycles per half-period while enabled and
// toggles SCLK on each wrap when toggling is allowed; rise/fall strobe that edge.
module spi_sclk_gen #(
  parameter int unsigned CLK_DIV = 1221
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic en_i,
  input  logic tog_en_i,
  output logic sclk_o,
  output logic tick_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             sclk_q, sclk_d;

  always_comb begin
    tick_o = en_i && (cnt_q == DIV_LAST);
    rise_o = tick_o && tog_en_i && !sclk_q;
    fall_o = tick_o && tog_en_i && sclk_q;
    cnt_d  = '0;
    if (en_i && !tick_o) begin
      cnt_d = cnt_q + DIV_W'(1);
    end
    sclk_d = sclk_q;
    if (!en_i) begin
      sclk_d = 1'b0;
    end else if (rise_o) begin
      sclk_d = 1'b1;
    end else if (fall_o) begin
      sclk_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk_o = sclk_q;

endmodule

// File: rtl/spi_burst_master.sv
// SPI mode-0 burst master: opcode/address header then up to MAX_BYTES data bytes.
// Define SPI_LOOPBACK_EN to receive from the internal MOSI instead of the MISO pin.
module spi_burst_master
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 1221,
  parameter int unsigned MAX_BYTES = 8,
  parameter int unsigned CS_GAP    = 4
) (
  input  logic                           CLK,
  input  logic                           RST_N,
  input  logic                           START,
  input  logic [7:0]                     OPCODE,
  input  logic [7:0]                     ADDRESS,
  input  logic [$clog2(MAX_BYTES+1)-1:0] NUM_BYTES,
  input  logic [7:0]                     WR_DATA,
  input  logic                           MISO,
  output logic                           CS,
  output logic                           SCLK,
  output logic                           MOSI,
  output logic                           WR_REQ,
  output logic [7:0]                     RD_DATA,
  output logic                           RD_VALID,
  output logic                           BUSY,
  output logic                           DONE,
  output logic                           ERR
);

  localparam int unsigned NB_W     = $clog2(MAX_BYTES + 1);
  localparam int unsigned GAP_CYC  = ((CS_GAP < 1) ? 1 : CS_GAP) * CLK_DIV;
  localparam int unsigned GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

  function automatic logic [NB_W-1:0] clamp_len(input logic [NB_W-1:0] n);
    if (n == '0) return NB_W'(1);
    if (n > NB_W'(MAX_BYTES)) return NB_W'(MAX_BYTES);
    return n;
  endfunction

  state_t            state_q, state_d;
  logic [7:0]        op_q, op_d;
  logic [NB_W-1:0]   nbytes_q, nbytes_d;
  logic [NB_W-1:0]   byte_q, byte_d;
  logic [3:0]        bit_q, bit_d;
  logic [14:0]       sh_q, sh_d;
  logic [6:0]        rx_q, rx_d;
  logic [7:0]        wr_buf_q, wr_buf_d;
  logic [7:0]        rd_data_q, rd_data_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_valid_q, rd_valid_d;
  logic              wr_req_q, wr_req_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              cs_q, cs_d;
  logic              mosi_q, mosi_d;

  logic        div_en, tog_en, tick, rise, fall, rx_bit;
  logic        is_write, last_byte;
  logic [3:0]  hdr_last;
  logic        nb_mosi;
  logic [14:0] nb_sh;

`ifdef SPI_LOOPBACK_EN
  assign rx_bit = mosi_q;
`else
  assign rx_bit = MISO;
`endif

  assign div_en    = (state_q == ST_SETUP) || (state_q == ST_HEADER) ||
                     (state_q == ST_DATA)  || (state_q == ST_HOLD);
  assign tog_en    = (state_q == ST_SETUP) || (state_q == ST_HEADER) ||
                     (state_q == ST_DATA);
  assign is_write  = (op_q == OP_WRITE);
  assign hdr_last  = (op_q == OP_FIFO_RD) ? 4'd7 : 4'd15;
  assign last_byte = (byte_q == nbytes_q - NB_W'(1));
  // First bit and remaining bits of the next data byte (reads clock out zeros).
  assign nb_mosi   = is_write ? wr_buf_q[7] : 1'b0;
  assign nb_sh     = is_write ? {wr_buf_q[6:0], 8'h00} : 15'h0000;

  spi_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk_i    (CLK),
    .rst_n_i  (RST_N),
    .en_i     (div_en),
    .tog_en_i (tog_en),
    .sclk_o   (SCLK),
    .tick_o   (tick),
    .rise_o   (rise),
    .fall_o   (fall)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    nbytes_d   = nbytes_q;
    byte_d     = byte_q;
    bit_d      = bit_q;
    sh_d       = sh_q;
    rx_d       = rx_q;
    wr_buf_d   = wr_req_q ? WR_DATA : wr_buf_q;
    rd_data_d  = rd_data_q;
    gap_d      = gap_q;
    rd_pend_d  = 1'b0;
    rd_valid_d = rd_pend_q;
    wr_req_d   = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    cs_d       = cs_q;
    mosi_d     = mosi_q;

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          if (op_valid(OPCODE)) begin
            state_d  = ST_SETUP;
            op_d     = OPCODE;
            nbytes_d = clamp_len(NUM_BYTES);
            busy_d   = 1'b1;
            cs_d     = 1'b0;
            mosi_d   = OPCODE[7];
            sh_d     = {OPCODE[6:0], ADDRESS};
            bit_d    = '0;
            byte_d   = '0;
            rx_d     = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      // The divider wrap that ends SETUP is the first SCLK rising edge.
      ST_SETUP: begin
        if (rise) state_d = ST_HEADER;
      end

      ST_HEADER: begin
        if (rise && is_write && (bit_q == hdr_last)) wr_req_d = 1'b1;
        if (fall) begin
          if (bit_q == hdr_last) begin
            state_d = ST_DATA;
            bit_d   = '0;
            mosi_d  = nb_mosi;
            sh_d    = nb_sh;
          end else begin
            bit_d  = bit_q + 4'd1;
            mosi_d = sh_q[14];
            sh_d   = {sh_q[13:0], 1'b0};
          end
        end
      end

      ST_DATA: begin
        if (rise) begin
          if (!is_write) begin
            rx_d = {rx_q[5:0], rx_bit};
            if (bit_q == 4'd7) begin
              rd_data_d = {rx_q, rx_bit};
              rd_pend_d = 1'b1;
            end
          end else if ((bit_q == 4'd7) && !last_byte) begin
            wr_req_d = 1'b1;
          end
        end
        if (fall) begin
          if (bit_q == 4'd7) begin
            bit_d = '0;
            if (last_byte) begin
              state_d = ST_HOLD;
              mosi_d  = 1'b0;
            end else begin
              byte_d = byte_q + NB_W'(1);
              mosi_d = nb_mosi;
              sh_d   = nb_sh;
            end
          end else begin
            bit_d  = bit_q + 4'd1;
            mosi_d = sh_q[14];
            sh_d   = {sh_q[13:0], 1'b0};
          end
        end
      end

      ST_HOLD: begin
        if (tick) begin
          state_d = ST_GAP;
          cs_d    = 1'b1;
        end
      end

      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = ST_IDLE;
          gap_d   = '0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      nbytes_q   <= '0;
      byte_q     <= '0;
      bit_q      <= '0;
      sh_q       <= '0;
      rx_q       <= '0;
      wr_buf_q   <= '0;
      rd_data_q  <= '0;
      gap_q      <= '0;
      rd_pend_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      wr_req_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cs_q       <= 1'b1;
      mosi_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      nbytes_q   <= nbytes_d;
      byte_q     <= byte_d;
      bit_q      <= bit_d;
      sh_q       <= sh_d;
      rx_q       <= rx_d;
      wr_buf_q   <= wr_buf_d;
      rd_data_q  <= rd_data_d;
      gap_q      <= gap_d;
      rd_pend_q  <= rd_pend_d;
      rd_valid_q <= rd_valid_d;
      wr_req_q   <= wr_req_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      cs_q       <= cs_d;
      mosi_q     <= mosi_d;
    end
  end

  assign CS       = cs_q;
  assign MOSI     = mosi_q;
  assign WR_REQ   = wr_req_q;
  assign RD_DATA  = rd_data_q;
  assign RD_VALID = rd_valid_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign ERR      = err_q;

endmodule

// File: tb/tb_spi_burst_master.sv
// Randomized bench for spi_burst_master: a slave/bus monitor records each frame and
// the results are compared with expectations computed from the transaction itself.
module tb_spi_burst_master;
  import spi_pkg::*;

  localparam int CLK_DIV   = 4;
  localparam int MAX_BYTES = 4;
  localparam int CS_GAP    = 2;
  localparam int NB_W      = $clog2(MAX_BYTES + 1);

`ifdef SPI_LOOPBACK_EN
  localparam bit LOOPBACK = 1'b1;
`else
  localparam bit LOOPBACK = 1'b0;
`endif

  logic            CLK = 1'b0;
  logic            RST_N = 1'b0;
  logic            START = 1'b0;
  logic [7:0]      OPCODE = 8'h00;
  logic [7:0]      ADDRESS = 8'h00;
  logic [NB_W-1:0] NUM_BYTES = '0;
  logic [7:0]      WR_DATA = 8'h00;
  logic            MISO = 1'b0;
  logic            CS, SCLK, MOSI, WR_REQ, RD_VALID, BUSY, DONE, ERR;
  logic [7:0]      RD_DATA;

  spi_burst_master #(
    .CLK_DIV   (CLK_DIV),
    .MAX_BYTES (MAX_BYTES),
    .CS_GAP    (CS_GAP)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .START     (START),
    .OPCODE    (OPCODE),
    .ADDRESS   (ADDRESS),
    .NUM_BYTES (NUM_BYTES),
    .WR_DATA   (WR_DATA),
    .MISO      (MISO),
    .CS        (CS),
    .SCLK      (SCLK),
    .MOSI      (MOSI),
    .WR_REQ    (WR_REQ),
    .RD_DATA   (RD_DATA),
    .RD_VALID  (RD_VALID),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .ERR       (ERR)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Slave / bus monitor state (written only by the monitor, except slave_bytes)
  logic [7:0]  slave_bytes [8];
  int          cyc = 0;
  logic        prev_sclk = 1'b0, prev_cs = 1'b1;
  logic [63:0] mosi_vec = '0;
  int          rise_cnt = 0, fall_cnt = 0;
  logic [7:0]  rd_q [$];
  int          last_edge = 0, last_rise = 0, wr_pend = -1, cs_rise_cyc = 0, gap_len = 0;
  int          wrreq_tot = 0, rv_tot = 0, done_tot = 0, err_tot = 0;
  int          half_bad = 0, wrlead_bad = 0, rvlat_bad = 0, inv_bad = 0;

  function automatic logic slave_bit(input int idx);
    if (idx >= 64) return 1'b0;
    return slave_bytes[idx / 8][7 - (idx % 8)];
  endfunction

  always @(negedge CLK) begin
    cyc++;
    if (RST_N) begin
      if (CS === 1'b1 && SCLK === 1'b1) inv_bad++;
      if (prev_cs && !CS) begin
        mosi_vec  = '0;
        rise_cnt  = 0;
        fall_cnt  = 0;
        rd_q.delete();
        last_edge = cyc;
        wr_pend   = -1;
        MISO      = slave_bit(0);
      end
      if (!prev_cs && CS) begin
        if (cyc - last_edge != CLK_DIV) half_bad++;
        cs_rise_cyc = cyc;
      end
      if (!prev_sclk && SCLK) begin
        if (cyc - last_edge != CLK_DIV) half_bad++;
        last_edge = cyc;
        last_rise = cyc;
        rise_cnt++;
        mosi_vec = {mosi_vec[62:0], MOSI};
      end
      if (prev_sclk && !SCLK) begin
        if (cyc - last_edge != CLK_DIV) half_bad++;
        last_edge = cyc;
        fall_cnt++;
        MISO = slave_bit(fall_cnt);
        if (wr_pend >= 0) begin
          if (cyc - wr_pend != CLK_DIV) wrlead_bad++;
          wr_pend = -1;
        end
      end
      if (WR_REQ) begin
        wrreq_tot++;
        if (wr_pend >= 0) wrlead_bad++;
        wr_pend = cyc;
      end
      if (RD_VALID) begin
        rv_tot++;
        rd_q.push_back(RD_DATA);
        if (cyc - last_rise != 1) rvlat_bad++;
      end
      if (DONE) begin
        done_tot++;
        gap_len = cyc - cs_rise_cyc;
      end
      if (ERR) err_tot++;
    end
    prev_sclk = SCLK;
    prev_cs   = CS;
  end

  task automatic run_txn(input logic [7:0] op, input logic [7:0] addr, input int n,
                         input logic [31:0] wbytes, input int mid, input bit fix_rd);
    int hdr, neff, widx;
    int s_wr, s_rv, s_done, s_err, s_half, s_wl, s_rl, s_inv;
    bit done_seen;
    logic [63:0] exp_mosi, exp_rd, act_rd;
    hdr  = (op == OP_FIFO_RD) ? 1 : 2;
    neff = (n == 0) ? 1 : ((n > MAX_BYTES) ? MAX_BYTES : n);
    for (int i = 0; i < 8; i++) slave_bytes[i] = 8'($urandom);
    if (fix_rd) slave_bytes[hdr] = 8'h5A;
    s_wr = wrreq_tot; s_rv = rv_tot; s_done = done_tot; s_err = err_tot;
    s_half = half_bad; s_wl = wrlead_bad; s_rl = rvlat_bad; s_inv = inv_bad;

    OPCODE = op; ADDRESS = addr; NUM_BYTES = NB_W'(n); START = 1'b1;
    @(negedge CLK);
    START = 1'b0; OPCODE = 8'($urandom); ADDRESS = 8'($urandom); NUM_BYTES = NB_W'($urandom);
    check_eq("busy_on", BUSY, 1);
    check_eq("cs_low", CS, 0);
    widx = 0;
    done_seen = 1'b0;
    for (int k = 0; k < 3000 && !done_seen; k++) begin
      @(negedge CLK);
      if (START) START = 1'b0;
      if (WR_REQ) begin
        WR_DATA = (widx < 4) ? 8'(wbytes >> (8 * (3 - widx))) : 8'hEE;
        widx++;
      end
      if (k == mid) begin
        START  = 1'b1;
        OPCODE = 8'h55;
      end
      if (DONE) done_seen = 1'b1;
    end
    START = 1'b0;
    check_eq("done_seen", done_seen, 1);
    repeat (2) @(negedge CLK);

    exp_mosi = {56'h0, op};
    if (hdr == 2) exp_mosi = {exp_mosi[55:0], addr};
    exp_rd = '0;
    for (int j = 0; j < neff; j++) begin
      exp_mosi = {exp_mosi[55:0], (op == OP_WRITE) ? 8'(wbytes >> (8 * (3 - j))) : 8'h00};
      if (op != OP_WRITE) exp_rd = {exp_rd[55:0], LOOPBACK ? 8'h00 : slave_bytes[hdr + j]};
    end
    act_rd = '0;
    foreach (rd_q[i]) act_rd = {act_rd[55:0], rd_q[i]};

    check_eq("busy_off", BUSY, 0);
    check_eq("cs_idle", CS, 1);
    check_eq("rises", rise_cnt, 8 * (hdr + neff));
    check_eq("mosi_seq", mosi_vec, exp_mosi);
    check_eq("rd_valid_cnt", rv_tot - s_rv, (op == OP_WRITE) ? 0 : neff);
    check_eq("rd_data", act_rd, exp_rd);
    check_eq("wr_req_cnt", wrreq_tot - s_wr, (op == OP_WRITE) ? neff : 0);
    check_eq("done_cnt", done_tot - s_done, 1);
    check_eq("err_cnt", err_tot - s_err, 0);
    check_eq("half_period", half_bad - s_half, 0);
    check_eq("wr_req_lead", wrlead_bad - s_wl, 0);
    check_eq("rd_valid_lat", rvlat_bad - s_rl, 0);
    check_eq("sclk_cs_high", inv_bad - s_inv, 0);
    check_eq("cs_gap", gap_len, CS_GAP * CLK_DIV);
    $display("txn op=%02h addr=%02h n=%0d neff=%0d rises=%0d mosi=%0h rd=%0h", op, addr, n, neff,
             rise_cnt, mosi_vec, act_rd);
  endtask

  initial begin
    int s_err, s_done, bad;
    logic [7:0] ops [3];
    ops[0] = OP_WRITE; ops[1] = OP_REG_RD; ops[2] = OP_FIFO_RD;

    repeat (3) @(negedge CLK);
    check_eq("rst_cs", CS, 1);
    check_eq("rst_sclk", SCLK, 0);
    check_eq("rst_mosi", MOSI, 0);
    check_eq("rst_rd_data", RD_DATA, 8'h00);
    check_eq("rst_strobes", {WR_REQ, RD_VALID, BUSY, DONE, ERR}, 5'b00000);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);

    run_txn(OP_REG_RD, ACC_X_ADDR, 1, 32'h0, -1, 1'b1);
    run_txn(OP_WRITE, 8'h2D, 2, 32'h0200_0000, -1, 1'b0);
    run_txn(OP_FIFO_RD, 8'h00, 6, 32'h0, 160, 1'b0);
    run_txn(OP_REG_RD, ACC_Y_ADDR, 1, 32'h0, -1, 1'b0);

    // Rejected opcode: one ERR, no bus activity.
    s_err = err_tot;
    OPCODE = 8'h55; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    bad = 0;
    repeat (10) begin
      if (CS !== 1'b1 || BUSY !== 1'b0) bad++;
      @(negedge CLK);
    end
    check_eq("reject_err", err_tot - s_err, 1);
    check_eq("reject_idle", bad, 0);
    $display("txn op=55 rejected err_pulses=%0d", err_tot - s_err);

    // Reset during the header aborts without DONE.
    s_done = done_tot;
    OPCODE = OP_REG_RD; ADDRESS = 8'h08; NUM_BYTES = NB_W'(1); START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (CLK_DIV * 6) @(negedge CLK);
    check_eq("hdr_cs_low", CS, 0);
    RST_N = 1'b0; START = 1'b1;
    @(negedge CLK);
    check_eq("abort_cs", CS, 1);
    check_eq("abort_sclk", SCLK, 0);
    check_eq("abort_busy", BUSY, 0);
    repeat (3) @(negedge CLK);
    RST_N = 1'b1; START = 1'b0;
    bad = 0;
    repeat (40) begin
      @(negedge CLK);
      if (CS !== 1'b1) bad++;
    end
    check_eq("abort_quiet", bad, 0);
    check_eq("abort_no_done", done_tot - s_done, 0);
    $display("txn reset-abort during header, done_pulses=%0d", done_tot - s_done);
    run_txn(OP_REG_RD, ACC_Z_ADDR, 1, 32'h0, -1, 1'b0);

    for (int t = 0; t < 8; t++) begin
      run_txn(ops[$urandom_range(0, 2)], 8'($urandom), int'($urandom_range(0, 7)), $urandom,
              ($urandom_range(0, 1) == 1) ? int'($urandom_range(20, 100)) : -1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
